// File: rtl/rob_squash_if.sv
// rtl/rob_squash_if.sv - dispatch/complete/squash/retire port bundle for the reorder buffer
interface rob_squash_if #(
    parameter int DEPTH = 32,
    parameter int N     = 3,
    parameter int TAG_W = 6,
    parameter int IDX_W = $clog2(DEPTH)
);
    localparam int ND_W  = $clog2(N + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ND_W-1:0]             num_dispatch;
    logic [N-1:0][TAG_W-1:0]     dispatch_t;
    logic [N-1:0][TAG_W-1:0]     dispatch_told;
    logic [N-1:0][IDX_W-1:0]     dispatch_idx;
    logic [N-1:0][TAG_W-1:0]     complete_t;
    logic                        squash_en;
    logic [IDX_W-1:0]            squash_idx;
    logic [N-1:0][TAG_W-1:0]     retire_t;
    logic [N-1:0][TAG_W-1:0]     retire_told;
    logic [ND_W-1:0]             num_retired;
    logic [CNT_W-1:0]            open_entries;

    modport master (
        output num_dispatch, dispatch_t, dispatch_told, complete_t, squash_en, squash_idx,
        input  dispatch_idx, retire_t, retire_told, num_retired, open_entries
    );

    modport slave (
        input  num_dispatch, dispatch_t, dispatch_told, complete_t, squash_en, squash_idx,
        output dispatch_idx, retire_t, retire_told, num_retired, open_entries
    );
endinterface

// File: rtl/rob_squash.sv
// rtl/rob_squash.sv - N-wide circular reorder buffer with tag completion and squash rollback
module rob_squash #(
    parameter int DEPTH = 32,
    parameter int N     = 3,
    parameter int TAG_W = 6,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    rob_squash_if.slave  rob
);
    localparam int ND_W  = $clog2(N + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] ent_t    [DEPTH];
    logic [TAG_W-1:0] ent_told [DEPTH];
    logic [DEPTH-1:0] ent_rdy;

    logic [ND_W-1:0]  nr;
    logic [ND_W-1:0]  accepted;
    logic [CNT_W-1:0] open_cnt;
    logic [IDX_W-1:0] sq_off;
    logic [CNT_W-1:0] keep_len;
    logic [CNT_W-1:0] live_end;
    logic             squash_ok;
    logic             hold;

    logic [DEPTH-1:0] rdy_next;
    logic [DEPTH-1:0] wr_en;
    logic [TAG_W-1:0] nxt_t    [DEPTH];
    logic [TAG_W-1:0] nxt_told [DEPTH];

    function automatic logic tag_hit(input logic [TAG_W-1:0] t,
                                     input logic [N-1:0][TAG_W-1:0] ct);
        logic h;
        h = 1'b0;
        for (int s = 0; s < N; s++)
            if (ct[s] != '0 && ct[s] == t)
                h = 1'b1;
        return h;
    endfunction

    assign open_cnt          = CNT_W'(DEPTH) - count;
    assign rob.open_entries  = open_cnt;
    assign accepted          = (CNT_W'(rob.num_dispatch) > open_cnt) ? ND_W'(open_cnt)
                                                                     : rob.num_dispatch;

    // The branch itself survives, so the kept run is head..squash_idx inclusive.
    assign sq_off    = rob.squash_idx - head;
    assign squash_ok = CNT_W'(sq_off) < count;
    assign keep_len  = CNT_W'(sq_off) + CNT_W'(1);
    assign hold      = rob.squash_en && !squash_ok;
    assign live_end  = rob.squash_en ? keep_len : count;

    always_comb begin
        for (int i = 0; i < N; i++)
            rob.dispatch_idx[i] = tail + IDX_W'(i);
    end

    always_comb begin : retire_logic
        logic             run;
        logic [IDX_W-1:0] idx;
        nr  = '0;
        run = 1'b1;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx                = head + IDX_W'(i);
            rob.retire_t[i]    = '0;
            rob.retire_told[i] = '0;
            if (run && CNT_W'(i) < count && ent_rdy[idx]) begin
                rob.retire_t[i]    = ent_t[idx];
                rob.retire_told[i] = ent_told[idx];
                nr                 = nr + ND_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end
    assign rob.num_retired = nr;

    // Entries still live after this edge keep/gain ready; popped and squashed ones drop it.
    always_comb begin : entry_next
        logic [IDX_W-1:0] off;
        logic             live;
        wr_en    = '0;
        rdy_next = '0;
        off      = '0;
        live     = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            nxt_t[j]    = ent_t[j];
            nxt_told[j] = ent_told[j];
            off         = IDX_W'(j) - head;
            live        = (CNT_W'(off) >= CNT_W'(nr)) && (CNT_W'(off) < live_end);
            rdy_next[j] = live && (ent_rdy[j] || tag_hit(ent_t[j], rob.complete_t));
            for (int s = 0; s < N; s++) begin
                if (!rob.squash_en && ND_W'(s) < accepted && (tail + IDX_W'(s)) == IDX_W'(j)) begin
                    wr_en[j]    = 1'b1;
                    nxt_t[j]    = rob.dispatch_t[s];
                    nxt_told[j] = rob.dispatch_told[s];
                    rdy_next[j] = tag_hit(rob.dispatch_t[s], rob.complete_t);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_rdy <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                ent_t[j]    <= '0;
                ent_told[j] <= '0;
            end
        end else if (!hold) begin
            head    <= head + IDX_W'(nr);
            tail    <= rob.squash_en ? rob.squash_idx + IDX_W'(1) : tail + IDX_W'(accepted);
            count   <= rob.squash_en ? keep_len - CNT_W'(nr)
                                     : count + CNT_W'(accepted) - CNT_W'(nr);
            ent_rdy <= rdy_next;
            for (int j = 0; j < DEPTH; j++) begin
                if (wr_en[j]) begin
                    ent_t[j]    <= nxt_t[j];
                    ent_told[j] <= nxt_told[j];
                end
            end
        end
    end
endmodule

// File: doc/rob_squash.md
# rob_squash

N-way superscalar reorder buffer for the R10K pipeline: a DEPTH-entry circular buffer with per-entry ready bits. It accepts up to N dispatches per cycle, marks entries complete by physical-tag match, and retires up to N in-order ready entries per cycle. Unlike the earlier fixed-shift ROB, it supports branch-mispredict squash with tail rollback and true wrap-around indexing. It also exports the ROB index of each dispatched entry so branch logic can name a squash point.

## Interface
- DEPTH, default 32: entry count; must be a power of two ≥ 2·N.
- N, default 3: dispatch, complete and retire width.
- TAG_W, default 6: physical register tag width. Tag 0 means "no tag".
- IDX_W, default $clog2(DEPTH): ROB index width.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- num_dispatch  in  $clog2(N+1)  number of valid dispatch slots, 0..N, packed from slot 0.
- dispatch_t  in  N×TAG_W  destination tag T per slot.
- dispatch_told  in  N×TAG_W  previous mapping T_old per slot.
- dispatch_idx  out  N×IDX_W  ROB index slot i will occupy: (tail+i) mod DEPTH.
- complete_t  in  N×TAG_W  completing tags; 0 = slot idle.
- squash_en  in  1  mispredict squash request.
- squash_idx  in  IDX_W  ROB index of the mispredicted branch; the branch survives.
- retire_t  out  N×TAG_W  T of retiring slots (head-relative, slot 0 oldest).
- retire_told  out  N×TAG_W  T_old of retiring slots, for freelist return.
- num_retired  out  $clog2(N+1)  retiring entry count this cycle.
- open_entries  out  $clog2(DEPTH+1)  DEPTH − count, from registered count.

## Operation
- State:
  - head, tail: IDX_W bits each, wrapping modulo DEPTH.
  - count: $clog2(DEPTH+1) bits.
  - Per entry: T, T_old, ready.
- Dispatch:
  - Accepted = min(num_dispatch, open_entries).
  - Slot i (i < accepted) is written to (tail+i) mod DEPTH with ready = 0.
  - tail advances by accepted.
  - Excess slots are silently dropped; the upstream stage must never exceed open_entries.
- Complete:
  - For every slot with complete_t ≠ 0, set ready on each occupied entry whose T equals complete_t.
  - Unoccupied entries never match.
  - Tags not present in the ROB are ignored.
- Retire:
  - num_retired = the length of the run of occupied, ready entries starting at head, capped at N and at count.
  - retire_t and retire_told slots at index ≥ num_retired are driven 0.
  - head advances by num_retired at the edge; the ready bits of the popped entries are cleared.
- Squash:
  - squash_en with squash_idx occupied sets tail ← (squash_idx+1) mod DEPTH and discards all younger entries.
  - Same-cycle dispatch is ignored.
  - Same-cycle completions to discarded entries are dropped.
  - Same-cycle retirement of older entries still proceeds.
  - New count = ((squash_idx − head) mod DEPTH) + 1 − num_retired.
  - A squash_idx that is not occupied is illegal; the block holds state unchanged and the bench flags an error.
- Count arithmetic:
  - count_next = count + accepted − num_retired, computed in $clog2(DEPTH+1) bits; it never over- or underflows.
  - Full is count == DEPTH; empty is count == 0. head == tail does not by itself distinguish the two.

## Timing
- Reset (asynchronous): head = tail = count = 0, all ready = 0, T = T_old = 0. Outputs: open_entries = DEPTH, num_retired = 0, retire_t = retire_told = 0, dispatch_idx[i] = i.
- Outputs:
  - retire_* and num_retired are combinational from registered state only. They are not combinational from this cycle's complete_t, so completion → retire takes at least 1 cycle.
  - open_entries and dispatch_idx are combinational from registers only, with no input→output paths.
- Latency:
  - Dispatch at edge k; the entry is retire-eligible in cycle k+1 only if it was completed at edge ≤ k.
  - An entry dispatched and completed in the same cycle has its ready bit set at that edge.
  - Minimum dispatch → retire latency is 1 cycle.
- Retirement frees slots at the edge; open_entries reflects them in the following cycle, not the same one.
- Reset asserted mid-operation discards all entries regardless of pending dispatch or squash.

## Test plan
- Reset, then idle: open_entries = DEPTH, num_retired = 0 for 5 cycles.
- DEPTH=8, N=3: dispatch 3 tags (5, 6, 7), then complete 6 and 7 only → num_retired = 0; complete 5 → next cycle num_retired = 3, retire_t = {5, 6, 7}.
- Fill to full (count 8) with num_dispatch = 3 while open_entries = 2 → only 2 are accepted; open_entries = 0; the next dispatch is dropped. Retire 3 → open_entries = 3.
- Wrap: run 20 dispatch/complete/retire rounds of 3 with DEPTH=8 → dispatch_idx wraps 6, 7, 0. Retire order matches dispatch order and count never exceeds 8.
- Squash: entries at idx 2..6, squash_idx = 3 while dispatching 2 → count = 2, tail = 4, and dispatch is ignored. A later completion of a squashed tag has no effect.
- Squash with simultaneous retire of the ready head (idx 2), squash_idx = 4 → num_retired = 1, count = 2, head = 3, tail = 5.
